// File: rtl/mantissa_norm_pipe.sv
// mantissa_norm_pipe: two-stage valid/ready normalizer for a 48-bit mantissa product.
//
// Stage 1 captures the raw product, its scale and a leading-zero count.
// Stage 2 shifts the product so its top set bit lands at bit 47. It then presents the
// 27 fraction bits below that hidden 1, a sticky OR of the dropped bits, and the
// adjusted exponent.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : upstream word valid
//   in_ready   : block accepts the word this cycle
//   in_sum     : unsigned 48-bit mantissa product, bit 46 = unit position
//   in_scale   : signed SW-bit scale of the product
//   flush      : synchronous clear of both stages
//   out_valid  : normalized result valid
//   out_ready  : downstream accepts the result
//   out_frac   : 27 fraction bits below the hidden 1
//   out_sticky : OR of the discarded low bits
//   out_exp    : signed SW+1-bit normalized exponent
//   out_zero   : input product was zero
module mantissa_norm_pipe #(
    parameter int unsigned SW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [47:0]   in_sum,
    input  logic [SW-1:0] in_scale,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [26:0]   out_frac,
    output logic          out_sticky,
    output logic [SW:0]   out_exp,
    output logic          out_zero
);

    // Stage 1 state
    logic          s1_valid_q, s1_valid_d;
    logic [47:0]   s1_sum_q;
    logic [SW-1:0] s1_scale_q;
    logic [5:0]    s1_lzc_q;
    logic [5:0]    lzc_d;

    // Stage 2 state
    logic          out_valid_q, out_valid_d;
    logic [26:0]   out_frac_q, out_frac_d;
    logic          out_sticky_q, out_sticky_d;
    logic [SW:0]   out_exp_q, out_exp_d;
    logic          out_zero_q, out_zero_d;

    logic          s1_load;
    logic          s2_load;
    logic [47:0]   norm;
    logic [SW:0]   scale_ext;
    logic [SW:0]   lzc_ext;
    logic [SW:0]   exp_calc;

    // Handshake
    assign s2_load  = s1_valid_q & (~out_valid_q | out_ready);
    assign in_ready = (~s1_valid_q | s2_load) & ~flush;
    assign s1_load  = in_valid & in_ready;

    // Leading-zero count: the highest set bit wins because it is visited last
    always_comb begin
        lzc_d = 6'd48;
        for (int i = 0; i < 48; i++) begin
            if (in_sum[i]) begin
                lzc_d = 6'(47 - i);
            end
        end
    end

    // Normalization
    assign norm      = s1_sum_q << s1_lzc_q;
    assign scale_ext = {s1_scale_q[SW-1], s1_scale_q};
    assign lzc_ext   = {{(SW - 5){1'b0}}, s1_lzc_q};
    assign exp_calc  = scale_ext + {{SW{1'b0}}, 1'b1} - lzc_ext;

    always_comb begin
        // After the shift, bit 47 is clear only when the product is zero
        out_zero_d   = ~norm[47];
        out_frac_d   = norm[46:20];
        out_sticky_d = |norm[19:0];
        out_exp_d    = out_zero_d ? '0 : exp_calc;
    end

    // Valid flags; flush wins over any load
    always_comb begin
        s1_valid_d  = s1_valid_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            s1_valid_d  = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid_d = 1'b1;
            end else if (s2_load) begin
                s1_valid_d = 1'b0;
            end
            if (s2_load) begin
                out_valid_d = 1'b1;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Stage 1 data needs no reset; it is qualified by s1_valid_q
    always_ff @(posedge clk) begin
        if (s1_load) begin
            s1_sum_q   <= in_sum;
            s1_scale_q <= in_scale;
            s1_lzc_q   <= lzc_d;
        end
    end

    // Output data resets to zero so the outputs read clean while in reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_frac_q   <= '0;
            out_sticky_q <= 1'b0;
            out_exp_q    <= '0;
            out_zero_q   <= 1'b0;
        end else if (s2_load) begin
            out_frac_q   <= out_frac_d;
            out_sticky_q <= out_sticky_d;
            out_exp_q    <= out_exp_d;
            out_zero_q   <= out_zero_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_frac   = out_frac_q;
    assign out_sticky = out_sticky_q;
    assign out_exp    = out_exp_q;
    assign out_zero   = out_zero_q;

endmodule

// File: tb/tb_mantissa_norm_pipe.sv
// tb_mantissa_norm_pipe: scoreboard bench for mantissa_norm_pipe.
// The driver pushes the model's expected result when a word is accepted.
// The monitor pops and compares when a result leaves the block.
`timescale 1ns/1ps
module tb_mantissa_norm_pipe;

    localparam int SW = 10;

    typedef struct packed {
        logic [26:0] frac;
        logic        sticky;
        logic [SW:0] exp;
        logic        zero;
    } res_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [47:0]   in_sum;
    logic [SW-1:0] in_scale;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [26:0]   out_frac;
    logic          out_sticky;
    logic [SW:0]   out_exp;
    logic          out_zero;

    int checks   = 0;
    int failures = 0;
    int n_acc    = 0;
    int n_out    = 0;
    int n_drop   = 0;
    logic last_ready;
    res_t exp_q[$];

    mantissa_norm_pipe #(.SW(SW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sum     (in_sum),
        .in_scale   (in_scale),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_frac   (out_frac),
        .out_sticky (out_sticky),
        .out_exp    (out_exp),
        .out_zero   (out_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Value = sum * 2^(scale-46). Written as 1.f * 2^e with the top set bit at position p,
    // so e = scale + p - 46 and f is the 27 bits just below position p.
    function automatic res_t model(input logic [47:0] s, input logic [SW-1:0] sc);
        res_t r;
        int p = -1;
        int e;
        logic [63:0] ss = {16'd0, s};
        logic [63:0] mask = (64'd1 << 27) - 64'd1;
        for (int i = 0; i < 48; i++) if (s[i]) p = i;
        r = '0;
        if (p < 0) begin
            r.zero = 1'b1;
            return r;
        end
        e = int'($signed(sc)) + p - 46;
        r.exp = e[SW:0];
        if (p >= 27) begin
            r.frac   = 27'((ss >> (p - 27)) & mask);
            r.sticky = (ss & ((64'd1 << (p - 27)) - 64'd1)) != 64'd0;
        end else begin
            r.frac   = 27'((ss << (27 - p)) & mask);
            r.sticky = 1'b0;
        end
        return r;
    endfunction

    // One clock: record acceptance at the negedge, then return just after the posedge
    task automatic step();
        @(negedge clk);
        last_ready = in_ready;
        if (rst_n && in_valid && in_ready) begin
            exp_q.push_back(model(in_sum, in_scale));
            n_acc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_word(input logic [47:0] s, input logic [SW-1:0] sc);
        int n = 0;
        in_valid = 1'b1;
        in_sum   = s;
        in_scale = sc;
        do begin
            step();
            n++;
        end while (!last_ready && n < 100);
        if (!last_ready) chk("accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic logic [47:0] rand_sum();
        logic [47:0] v = {$urandom(), $urandom()};
        if ($urandom_range(0, 15) == 0) return 48'd0;
        return v >> $urandom_range(0, 47);
    endfunction

    // Monitor
    initial begin
        res_t held;
        res_t e;
        bit have_hold = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                have_hold = 0;
            end else begin
                if (have_hold) begin
                    chk("hold_stable", 64'({out_frac, out_sticky, out_exp, out_zero}), 64'(held));
                    have_hold = 0;
                end
                if (out_valid && out_ready) begin
                    n_out++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_frac", 64'(out_frac), 64'(e.frac));
                        chk("out_sticky", 64'(out_sticky), 64'(e.sticky));
                        chk("out_exp", 64'(out_exp), 64'(e.exp));
                        chk("out_zero", 64'(out_zero), 64'(e.zero));
                    end
                end else if (out_valid) begin
                    held = {out_frac, out_sticky, out_exp, out_zero};
                    have_hold = 1;
                end
                if (flush) begin
                    chk("in_ready_flush", 64'(in_ready), 64'd0);
                    n_drop += exp_q.size();
                    exp_q.delete();
                    have_hold = 0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sum = '0; in_scale = '0;
        flush = 1'b0; out_ready = 1'b1;
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_frac", 64'(out_frac), 64'd0);
        chk("rst_out_sticky", 64'(out_sticky), 64'd0);
        chk("rst_out_exp", 64'(out_exp), 64'd0);
        chk("rst_out_zero", 64'(out_zero), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("in_ready_after_reset", 64'(in_ready), 64'd1);

        // Directed corner words
        drive_word(48'h4000_0000_0000, 10'sd5);
        drive_word(48'h8000_0000_0001, -10'sd3);
        drive_word(48'h0000_0000_0001, 10'sd0);
        drive_word(48'h0000_0000_0000, 10'sd7);
        idle(4);

        // Backpressure: two words fill the pipe, the third must wait
        out_ready = 1'b0;
        drive_word(48'h0123_4567_89AB, 10'sd12);
        drive_word(48'h7FFF_FFFF_FFFF, -10'sd100);
        in_valid = 1'b1; in_sum = 48'h0000_00AB_CDEF; in_scale = 10'sd300;
        step();
        chk("in_ready_full", 64'(last_ready), 64'd0);
        step();
        chk("in_ready_full2", 64'(last_ready), 64'd0);
        out_ready = 1'b1;
        drive_word(48'h0000_00AB_CDEF, 10'sd300);
        idle(4);

        // Flush with two words in flight
        out_ready = 1'b0;
        drive_word(48'hABCD_EF12_3456, 10'sd1);
        drive_word(48'h0000_0F00_000F, -10'sd9);
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        idle(4);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        drive_word(48'hABCD_EF12_3456, 10'sd4);
        drive_word(48'h1357_9BDF_2468, 10'sd8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out_frac", 64'(out_frac), 64'd0);
        chk("arst_out_exp", 64'(out_exp), 64'd0);
        n_drop += exp_q.size();
        exp_q.delete();
        idle(2);
        rst_n = 1'b1;
        #1;
        chk("in_ready_rerelease", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        idle(4);

        // Random traffic; an unaccepted word is held until it is taken
        for (int c = 0; c < 14000; c++) begin
            if (!in_valid || last_ready) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_sum   = rand_sum();
                in_scale = SW'($urandom());
            end
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 299) == 0);
            step();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        idle(6);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        chk("transfer_count", 64'(n_out + n_drop), 64'(n_acc));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
